pong_score_keeper: RTL and testbench

- Rally/score controller for the ping-pong game; sits directly upstream of the seven-segment score display.
- Consumes single-cycle point events from the ball/paddle logic and a start button.
- Sequences serve → rally → pause → serve, keeps both BCD-range scores (0–9) and declares a winner.
- Drives the display's two 4-bit score inputs; provides ball-release and game-status signals back to the game logic.

---
 rtl/pong_score_keeper.sv | 151 +++++++++++++++
 tb/tb_pong_score_keeper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_score_keeper.sv
// Rally/score controller: sequences serve, rally, post-point pause and game over; keeps both scores.
// All outputs registered; point pulse to score is 1 clk, pause to ball_release is PAUSE_MS ticks + 1 clk.
module pong_score_keeper #(
    parameter int WIN_SCORE = 9,
    parameter int PAUSE_MS  = 1000,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1ms,
    input  logic       start,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       ball_release,
    output logic       serve_side,
    output logic       in_play,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        RALLY,
        POINT_PAUSE,
        GAME_OVER
    } state_t;

    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_MS);

    state_t           state_q, state_d;
    logic             start_q;
    logic             start_rise;
    logic [3:0]       p1_q, p1_d, p2_q, p2_d;
    logic [3:0]       p1_inc, p2_inc;
    logic             side_q, side_d;
    logic [1:0]       win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ball_release_q, in_play_q, game_over_q;

    assign start_rise = start & ~start_q;
    assign p1_inc     = p1_q + 4'd1;
    assign p2_inc     = p2_q + 4'd1;

    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        side_d  = side_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                p1_d = 4'd0;
                p2_d = 4'd0;
                if (start_rise) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                state_d = RALLY;
            end
            RALLY: begin
                // simultaneous points are a let: replay the serve without scoring
                if (p1_point && p2_point) begin
                    state_d = POINT_PAUSE;
                    cnt_d   = '0;
                end else if (p1_point) begin
                    p1_d   = p1_inc;
                    side_d = 1'b1;
                    if (p1_inc == WIN) begin
                        state_d = GAME_OVER;
                        win_d   = 2'b01;
                    end else begin
                        state_d = POINT_PAUSE;
                        cnt_d   = '0;
                    end
                end else if (p2_point) begin
                    p2_d   = p2_inc;
                    side_d = 1'b0;
                    if (p2_inc == WIN) begin
                        state_d = GAME_OVER;
                        win_d   = 2'b10;
                    end else begin
                        state_d = POINT_PAUSE;
                        cnt_d   = '0;
                    end
                end
            end
            POINT_PAUSE: begin
                if (tick_1ms) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == PAUSE_LAST) begin
                        state_d = SERVE;
                    end
                end
            end
            GAME_OVER: begin
                if (start_rise) begin
                    p1_d    = 4'd0;
                    p2_d    = 4'd0;
                    win_d   = 2'b00;
                    side_d  = 1'b0;
                    state_d = SERVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            start_q        <= 1'b0;
            p1_q           <= 4'd0;
            p2_q           <= 4'd0;
            side_q         <= 1'b0;
            win_q          <= 2'b00;
            cnt_q          <= '0;
            ball_release_q <= 1'b0;
            in_play_q      <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start;
            p1_q           <= p1_d;
            p2_q           <= p2_d;
            side_q         <= side_d;
            win_q          <= win_d;
            cnt_q          <= cnt_d;
            ball_release_q <= (state_d == SERVE);
            in_play_q      <= (state_d == RALLY);
            game_over_q    <= (state_d == GAME_OVER);
        end
    end

    assign p1_score     = p1_q;
    assign p2_score     = p2_q;
    assign ball_release = ball_release_q;
    assign serve_side   = side_q;
    assign in_play      = in_play_q;
    assign game_over    = game_over_q;
    assign winner       = win_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: directed game flow plus random rallies scored against a point-level model.
module tb_pong_score_keeper;

    localparam int WIN_SCORE = 3;
    localparam int PAUSE_MS  = 4;
    localparam int CNT_W     = 3;

    logic       clk = 1'b0;
    logic       reset, tick_1ms, start, p1_point, p2_point;
    logic [3:0] p1_score, p2_score;
    logic       ball_release, serve_side, in_play, game_over;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    // model of the game: scores, who serves next, who won
    int m_p1, m_p2, m_side, m_win;

    pong_score_keeper #(
        .WIN_SCORE(WIN_SCORE),
        .PAUSE_MS (PAUSE_MS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1ms    (tick_1ms),
        .start       (start),
        .p1_point    (p1_point),
        .p2_point    (p2_point),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .ball_release(ball_release),
        .serve_side  (serve_side),
        .in_play     (in_play),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "/p1_score"},   8'(p1_score),   8'(m_p1));
        chk({tag, "/p2_score"},   8'(p2_score),   8'(m_p2));
        chk({tag, "/serve_side"}, 8'(serve_side), 8'(m_side));
        chk({tag, "/winner"},     8'(winner),     8'(m_win));
        chk({tag, "/game_over"},  8'(game_over),  8'(m_win != 0));
    endtask

    // who: 1 = player 1 scores, 2 = player 2 scores, 3 = both (let)
    task automatic point(input int who, input string tag);
        int n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            tick_1ms = 1'b1;
            cyc();
            tick_1ms = 1'b0;
            chk({tag, "/rally_tick_in_play"}, 8'(in_play), 8'd1);
        end
        p1_point = (who == 1 || who == 3);
        p2_point = (who == 2 || who == 3);
        cyc();
        p1_point = 1'b0;
        p2_point = 1'b0;
        if (who == 1) begin
            m_p1++;
            m_side = 1;
            if (m_p1 == WIN_SCORE) m_win = 1;
        end else if (who == 2) begin
            m_p2++;
            m_side = 0;
            if (m_p2 == WIN_SCORE) m_win = 2;
        end
        chk_state({tag, "/point"});
        chk({tag, "/point_in_play"}, 8'(in_play), 8'd0);
        chk({tag, "/point_release"}, 8'(ball_release), 8'd0);
    endtask

    // PAUSE_MS ticks with random gaps full of ignored point pulses and start toggles
    task automatic do_pause(input string tag);
        for (int k = 1; k <= PAUSE_MS; k++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                p1_point = 1'($urandom_range(0, 1));
                p2_point = ~p1_point;
                start    = 1'($urandom_range(0, 1));
                cyc();
                p1_point = 1'b0;
                p2_point = 1'b0;
                chk({tag, "/pause_hold"}, 8'(ball_release), 8'd0);
                chk_state({tag, "/pause"});
            end
            tick_1ms = 1'b1;
            cyc();
            tick_1ms = 1'b0;
            chk({tag, "/pause_tick_release"}, 8'(ball_release), 8'(k == PAUSE_MS));
        end
        // a point arriving during SERVE is dropped
        p2_point = 1'b1;
        cyc();
        p2_point = 1'b0;
        chk({tag, "/rally_in_play"}, 8'(in_play), 8'd1);
        chk({tag, "/rally_release"}, 8'(ball_release), 8'd0);
        chk_state({tag, "/after_serve"});
    endtask

    task automatic restart(input string tag);
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        m_p1 = 0; m_p2 = 0; m_side = 0; m_win = 0;
        chk({tag, "/release"}, 8'(ball_release), 8'd1);
        chk_state({tag, "/cleared"});
        cyc();
        chk({tag, "/in_play"}, 8'(in_play), 8'd1);
        chk({tag, "/release_end"}, 8'(ball_release), 8'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; tick_1ms = 1'b0; p1_point = 1'b0; p2_point = 1'b0;
        m_p1 = 0; m_p2 = 0; m_side = 0; m_win = 0;
        cyc();
        cyc();
        chk_state("reset");
        chk("reset/release", 8'(ball_release), 8'd0);
        chk("reset/in_play", 8'(in_play), 8'd0);

        reset = 1'b1;
        cyc();
        chk("idle/release", 8'(ball_release), 8'd0);
        start = 1'b1;
        cyc();
        chk("start/release", 8'(ball_release), 8'd1);
        chk("start/in_play", 8'(in_play), 8'd0);
        cyc();
        chk("start/release_end", 8'(ball_release), 8'd0);
        chk("start/in_play2", 8'(in_play), 8'd1);
        chk_state("start");

        point(1, "p1_first");
        do_pause("p1_first");
        point(3, "let");
        do_pause("let");
        for (int i = 0; i < 3; i++) begin
            point(2, "p2_run");
            if (m_win == 0) do_pause("p2_run");
        end
        chk("p2_win/winner", 8'(winner), 8'd2);
        chk("p2_win/p2_score", 8'(p2_score), 8'd3);

        for (int i = 0; i < 3; i++) begin
            p1_point = 1'(i % 2);
            p2_point = ~p1_point;
            tick_1ms = 1'b1;
            cyc();
            p1_point = 1'b0; p2_point = 1'b0; tick_1ms = 1'b0;
            chk_state("over_frozen");
            chk("over_frozen/release", 8'(ball_release), 8'd0);
        end
        restart("restart1");

        for (int n = 0; n < 40 && m_win == 0; n++) begin
            point($urandom_range(1, 3), "random");
            if (m_win == 0) do_pause("random");
        end
        restart("restart2");

        point(1, "mid_a");
        do_pause("mid_a");
        point(1, "mid_b");
        do_pause("mid_b");
        point(2, "mid_c");
        chk("mid/p1_score", 8'(p1_score), 8'd2);
        chk("mid/p2_score", 8'(p2_score), 8'd1);
        tick_1ms = 1'b1;
        cyc();
        cyc();
        tick_1ms = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        cyc();
        m_p1 = 0; m_p2 = 0; m_side = 0; m_win = 0;
        chk_state("mid_reset");
        chk("mid_reset/release", 8'(ball_release), 8'd0);
        chk("mid_reset/in_play", 8'(in_play), 8'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p1_point = 1'b1; tick_1ms = 1'b1;
            cyc();
            p1_point = 1'b0; tick_1ms = 1'b0;
            chk("idle_stay/release", 8'(ball_release), 8'd0);
            chk("idle_stay/in_play", 8'(in_play), 8'd0);
            chk_state("idle_stay");
        end
        start = 1'b1;
        cyc();
        chk("final_start/release", 8'(ball_release), 8'd1);
        cyc();
        chk("final_start/in_play", 8'(in_play), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
